// File: rtl/core_pkg.sv
// Shared types for the core memory arbiter slice.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DRAIN_I
  } mem_arb_state_e;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } mem_grant_e;

  localparam int unsigned CORE_ADDR_W = 32;
  localparam int unsigned CORE_DATA_W = 32;

  // Request fields as latched toward the memory port (default widths).
  typedef struct packed {
    logic [CORE_ADDR_W-1:0]   addr;
    logic                     wen;
    logic [CORE_DATA_W-1:0]   wdata;
    logic [CORE_DATA_W/8-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/core_mem_arb_prio.sv
// Grant decision for the memory arbiter: data has fixed priority, but fetch
// is forced through after MAX_DATA_STREAK consecutive contested data grants.
module core_mem_arb_prio
  import core_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arb_en,
  input  logic       flush,
  input  logic       i_req_valid,
  input  logic       d_req_valid,
  output logic       grant_valid,
  output mem_grant_e grant
);

  localparam int unsigned SW = $clog2(MAX_DATA_STREAK + 1);

  logic [SW-1:0] streak_q;
  logic          fetch_forced;

  // Pick the winner for this cycle; fetch is never granted while flush is high.
  always_comb begin
    grant_valid  = 1'b0;
    grant        = GRANT_D;
    fetch_forced = (streak_q == SW'(MAX_DATA_STREAK));
    if (arb_en) begin
      if (i_req_valid && !flush && (!d_req_valid || fetch_forced)) begin
        grant_valid = 1'b1;
        grant       = GRANT_I;
      end else if (d_req_valid) begin
        grant_valid = 1'b1;
        grant       = GRANT_D;
      end
    end
  end

  // Count contested data grants; saturate at the limit, clear otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else if (grant_valid) begin
      if (grant == GRANT_I || !i_req_valid) begin
        streak_q <= '0;
      end else if (!fetch_forced) begin
        streak_q <= streak_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares the single memory request port between instruction fetch and data
// access, one outstanding transaction at a time, and drains flushed fetches.
module core_mem_arbiter
  import core_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                i_req_valid,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_rsp_ready,
  output logic [DATA_W-1:0]   i_rsp_rdata,
  input  logic                d_req_valid,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic                d_req_wen,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wmask,
  output logic                d_rsp_ready,
  output logic [DATA_W-1:0]   d_rsp_rdata,
  output logic                m_req_valid,
  output logic [ADDR_W-1:0]   m_req_addr,
  output logic                m_req_wen,
  output logic [DATA_W-1:0]   m_req_wdata,
  output logic [DATA_W/8-1:0] m_req_wmask,
  input  logic                m_rsp_ready,
  input  logic [DATA_W-1:0]   m_rsp_rdata
);

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic                wen;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wmask;
  } req_t;

  mem_arb_state_e state_q, state_d;
  req_t           req_q;
  logic           arb_en;
  logic           grant_valid;
  mem_grant_e     grant;

  core_mem_arb_prio #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_prio (
    .clk        (clk),
    .rst        (rst),
    .arb_en     (arb_en),
    .flush      (flush),
    .i_req_valid(i_req_valid),
    .d_req_valid(d_req_valid),
    .grant_valid(grant_valid),
    .grant      (grant)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Capture the winning request's fields; held for the whole transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= '0;
    end else if (grant_valid) begin
      if (grant == GRANT_I) begin
        req_q.addr  <= i_req_addr;
        req_q.wen   <= 1'b0;
        req_q.wdata <= '0;
        req_q.wmask <= '0;
      end else begin
        req_q.addr  <= d_req_addr;
        req_q.wen   <= d_req_wen;
        req_q.wdata <= d_req_wdata;
        req_q.wmask <= d_req_wmask;
      end
    end
  end

  // Next state and response routing; a flush turns a live fetch into a drain
  // so its eventual response is swallowed rather than delivered.
  always_comb begin
    state_d     = state_q;
    arb_en      = 1'b0;
    m_req_valid = (state_q != IDLE);
    i_rsp_ready = 1'b0;
    d_rsp_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        arb_en = 1'b1;
        if (grant_valid) state_d = (grant == GRANT_I) ? BUSY_I : BUSY_D;
      end
      BUSY_I: begin
        if (m_rsp_ready) begin
          i_rsp_ready = !flush;
          state_d     = IDLE;
        end else if (flush) begin
          state_d = DRAIN_I;
        end
      end
      BUSY_D: begin
        if (m_rsp_ready) begin
          d_rsp_ready = 1'b1;
          state_d     = IDLE;
        end
      end
      DRAIN_I: begin
        if (m_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_req_addr  = req_q.addr;
  assign m_req_wen   = req_q.wen;
  assign m_req_wdata = req_q.wdata;
  assign m_req_wmask = req_q.wmask;
  assign i_rsp_rdata = m_rsp_rdata;
  assign d_rsp_rdata = m_rsp_rdata;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: transaction-level model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_core_mem_arbiter;
  import core_pkg::*;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        i_rsp_ready;
  logic [31:0] i_rsp_rdata;
  logic        d_req_valid;
  logic [31:0] d_req_addr;
  logic        d_req_wen;
  logic [31:0] d_req_wdata;
  logic [3:0]  d_req_wmask;
  logic        d_rsp_ready;
  logic [31:0] d_rsp_rdata;
  logic        m_req_valid;
  logic [31:0] m_req_addr;
  logic        m_req_wen;
  logic [31:0] m_req_wdata;
  logic [3:0]  m_req_wmask;
  logic        m_rsp_ready;
  logic [31:0] m_rsp_rdata;

  int tests = 0;
  int fails = 0;
  int lat   = 1;
  bit cmp_en = 1'b0;

  core_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(MAXS)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
    .i_rsp_ready(i_rsp_ready), .i_rsp_rdata(i_rsp_rdata),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr),
    .d_req_wen(d_req_wen), .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask),
    .d_rsp_ready(d_rsp_ready), .d_rsp_rdata(d_rsp_rdata),
    .m_req_valid(m_req_valid), .m_req_addr(m_req_addr), .m_req_wen(m_req_wen),
    .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
    .m_rsp_ready(m_rsp_ready), .m_rsp_rdata(m_rsp_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Downstream memory: answers lat cycles after the request is first seen.
  initial begin
    int  cnt;
    bit  fire;
    cnt = 0;
    fire = 1'b0;
    m_rsp_ready = 1'b0;
    m_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || m_rsp_ready) begin
        cnt  = 0;
        fire = 1'b0;
      end else if (m_req_valid) begin
        cnt++;
        fire = (cnt >= lat);
      end
      @(posedge clk);
      #1;
      m_rsp_ready = fire;
      m_rsp_rdata = fire ? mem_rd(m_req_addr) : 32'h0;
    end
  end

  // Transaction-level model: one owner at a time, kill flag for flushed fetch.
  bit          md_busy = 1'b0, md_owner_d = 1'b0, md_killed = 1'b0;
  logic [31:0] md_addr = '0, md_wdata = '0;
  logic        md_wen = 1'b0;
  logic [3:0]  md_wmask = '0;
  int          md_streak = 0;
  int          glog[$];
  int          dlog[$];
  bit          prev_mv = 1'b0;

  // Compare DUT outputs against the model, then advance the model.
  always @(negedge clk) begin
    bit e_i, e_d, fetch_ok;
    if (cmp_en) begin
      e_i = md_busy && !md_owner_d && !md_killed && m_rsp_ready && !flush;
      e_d = md_busy && md_owner_d && m_rsp_ready;
      check("m_req_valid", m_req_valid, md_busy);
      check("m_req_addr", m_req_addr, md_addr);
      check("m_req_wen", m_req_wen, md_wen);
      check("m_req_wdata", m_req_wdata, md_wdata);
      check("m_req_wmask", m_req_wmask, md_wmask);
      check("i_rsp_ready", i_rsp_ready, e_i);
      check("d_rsp_ready", d_rsp_ready, e_d);
      if (e_i) check("i_rsp_rdata", i_rsp_rdata, mem_rd(md_addr));
      if (e_d) check("d_rsp_rdata", d_rsp_rdata, mem_rd(md_addr));
      if (m_req_valid && !prev_mv) dlog.push_back(m_req_addr == 32'h2000 ? 1 : 0);
      prev_mv = m_req_valid;
    end
    if (rst) begin
      md_busy = 0; md_killed = 0; md_streak = 0;
      md_addr = '0; md_wen = 0; md_wdata = '0; md_wmask = '0;
    end else if (md_busy) begin
      if (m_rsp_ready) begin
        md_busy = 0; md_killed = 0;
      end else if (!md_owner_d && flush) begin
        md_killed = 1;
      end
    end else begin
      fetch_ok = i_req_valid && !flush && (!d_req_valid || md_streak == MAXS);
      if (fetch_ok) begin
        md_busy = 1; md_owner_d = 0; md_streak = 0;
        md_addr = i_req_addr; md_wen = 0; md_wdata = '0; md_wmask = '0;
        glog.push_back(0);
      end else if (d_req_valid) begin
        md_busy = 1; md_owner_d = 1;
        md_streak = i_req_valid ? ((md_streak < MAXS) ? md_streak + 1 : MAXS) : 0;
        md_addr = d_req_addr; md_wen = d_req_wen;
        md_wdata = d_req_wdata; md_wmask = d_req_wmask;
        glog.push_back(1);
      end
    end
  end

  // Wait (bounded) for a response pulse, then retire the request.
  task automatic wait_rsp(input bit is_d, input logic [31:0] addr);
    bit got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (is_d ? d_rsp_ready : i_rsp_ready) begin
        got = 1'b1;
        break;
      end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL rsp_timeout: got no response expected pulse for %0h", addr);
    end else if (is_d) begin
      check("wait_d_rdata", d_rsp_rdata, mem_rd(addr));
      check("wait_d_no_i", i_rsp_ready, 1'b0);
    end else begin
      check("wait_i_rdata", i_rsp_rdata, mem_rd(addr));
    end
    @(posedge clk); #1;
    if (is_d) d_req_valid = 1'b0;
    else      i_req_valid = 1'b0;
  endtask

  initial begin
    int exp_ord[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    bit done;
    rst = 1'b1; flush = 1'b0;
    i_req_valid = 0; i_req_addr = '0;
    d_req_valid = 0; d_req_addr = '0; d_req_wen = 0; d_req_wdata = '0; d_req_wmask = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; cmp_en = 1'b1;
    @(negedge clk);
    check("reset_m_valid", m_req_valid, 1'b0);
    check("reset_m_addr", m_req_addr, 32'h0);
    check("reset_streak", dut.u_prio.streak_q, 0);

    // Fetch only, latency 1.
    @(posedge clk); #1 i_req_valid = 1; i_req_addr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    check("f1_valid_T1", m_req_valid, 1'b1);
    check("f1_addr_T1", m_req_addr, 32'h100);
    @(negedge clk);
    check("f1_rsp_T2", i_rsp_ready, 1'b1);
    check("f1_rdata_T2", i_rsp_rdata, mem_rd(32'h100));
    @(posedge clk); #1 i_req_valid = 0;
    @(negedge clk);
    check("f1_idle_T3", m_req_valid, 1'b0);

    // Contested stream, expected D,D,D,D,I,D,D,D,D,I.
    glog.delete(); dlog.delete();
    @(posedge clk); #1;
    i_req_valid = 1; i_req_addr = 32'h1000;
    d_req_valid = 1; d_req_addr = 32'h2000; d_req_wen = 0;
    done = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (glog.size() >= 10 && i_rsp_ready) begin done = 1'b1; break; end
    end
    check("contest_done", done, 1'b1);
    @(posedge clk); #1 i_req_valid = 0; d_req_valid = 0;
    check("glog_len", glog.size(), 10);
    check("dlog_len", dlog.size(), 10);
    for (int k = 0; k < 10; k++) begin
      if (k < glog.size()) check("grant_order_model", glog[k], exp_ord[k]);
      if (k < dlog.size()) check("grant_order_dut", dlog[k], exp_ord[k]);
    end

    // Store.
    @(posedge clk); #1;
    d_req_valid = 1; d_req_addr = 32'h40; d_req_wen = 1;
    d_req_wdata = 32'hCAFE_F00D; d_req_wmask = 4'hF;
    @(negedge clk);
    @(negedge clk);
    check("st_valid", m_req_valid, 1'b1);
    check("st_addr", m_req_addr, 32'h40);
    check("st_wen", m_req_wen, 1'b1);
    check("st_wdata", m_req_wdata, 32'hCAFE_F00D);
    check("st_wmask", m_req_wmask, 4'hF);
    wait_rsp(1'b1, 32'h40);
    d_req_wen = 0;

    // Flush while fetch is in flight, latency 3.
    lat = 3;
    @(posedge clk); #1 i_req_valid = 1; i_req_addr = 32'h200;
    @(negedge clk);
    @(posedge clk); #1 flush = 1; i_req_valid = 0;
    @(negedge clk);
    check("fl_busy", m_req_valid, 1'b1);
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    check("fl_drain_valid", m_req_valid, 1'b1);
    @(posedge clk); #1 flush = 1;
    @(negedge clk);
    check("fl_drain_valid2", m_req_valid, 1'b1);
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    check("fl_mrsp", m_rsp_ready, 1'b1);
    check("fl_no_irsp", i_rsp_ready, 1'b0);
    @(negedge clk);
    check("fl_idle", m_req_valid, 1'b0);
    lat = 1;
    @(posedge clk); #1 i_req_valid = 1; i_req_addr = 32'h300;
    wait_rsp(1'b0, 32'h300);

    // Flush coincident with the response, latency 2.
    lat = 2;
    @(posedge clk); #1 i_req_valid = 1; i_req_addr = 32'h180;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 flush = 1; i_req_valid = 0;
    @(negedge clk);
    check("co_mrsp", m_rsp_ready, 1'b1);
    check("co_no_irsp", i_rsp_ready, 1'b0);
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    check("co_idle", m_req_valid, 1'b0);

    // Flush in IDLE blocks the fetch grant for that cycle.
    @(posedge clk); #1 i_req_valid = 1; i_req_addr = 32'h500; flush = 1;
    @(negedge clk);
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    check("idle_flush_nogrant", m_req_valid, 1'b0);
    @(negedge clk);
    check("idle_flush_late_grant", m_req_valid, 1'b1);
    check("idle_flush_addr", m_req_addr, 32'h500);
    wait_rsp(1'b0, 32'h500);

    // Reset during a contested data transaction.
    lat = 3;
    @(posedge clk); #1;
    d_req_valid = 1; d_req_addr = 32'h80; d_req_wen = 1;
    d_req_wdata = 32'h1122_3344; d_req_wmask = 4'h3;
    i_req_valid = 1; i_req_addr = 32'h84;
    @(negedge clk);
    @(negedge clk);
    check("rs_busy_addr", m_req_addr, 32'h80);
    check("rs_streak1", dut.u_prio.streak_q, 1);
    @(posedge clk); #1 rst = 1; d_req_valid = 0; i_req_valid = 0;
    @(negedge clk);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("rs_m_valid", m_req_valid, 1'b0);
    check("rs_m_addr", m_req_addr, 32'h0);
    check("rs_m_wen", m_req_wen, 1'b0);
    check("rs_m_wdata", m_req_wdata, 32'h0);
    check("rs_m_wmask", m_req_wmask, 4'h0);
    check("rs_i_rsp", i_rsp_ready, 1'b0);
    check("rs_d_rsp", d_rsp_ready, 1'b0);
    check("rs_state", dut.state_q, IDLE);
    check("rs_streak0", dut.u_prio.streak_q, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Shares the core's single memory/MMU request port between instruction fetch (core_s1) and data access (core_s2). Grants one outstanding transaction at a time, with data given fixed priority and a bounded-streak anti-starvation rule for fetch. Routes each response back to its owner and silently drains in-flight fetches killed by a trap flush.

## Interface
- ADDR_W, 32, request address width
- DATA_W, 32, read/write data width
- MAX_DATA_STREAK, 4, max consecutive contested data grants before fetch is forced; ≥1
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  trap_occurred from core_s1; kills in-flight/pending fetch
- i_req_valid  in  1  fetch request
- i_req_addr  in  ADDR_W  fetch address
- i_rsp_ready  out  1  one-cycle fetch completion pulse
- i_rsp_rdata  out  DATA_W  fetched instruction, valid with i_rsp_ready
- d_req_valid  in  1  data request
- d_req_addr  in  ADDR_W  data address
- d_req_wen  in  1  1 = store
- d_req_wdata  in  DATA_W  store data
- d_req_wmask  in  DATA_W/8  byte enables
- d_rsp_ready  out  1  one-cycle data completion pulse
- d_rsp_rdata  out  DATA_W  load data, valid with d_rsp_ready
- m_req_valid  out  1  downstream request
- m_req_addr, m_req_wen, m_req_wdata, m_req_wmask  out  as above  latched request fields
- m_rsp_ready  in  1  downstream completion pulse
- m_rsp_rdata  in  DATA_W  downstream read data

## Operation
- Requester protocol: hold valid and fields stable until rsp_ready pulse; may drop valid without completion only for fetch on flush.
- FSM states: IDLE, BUSY_I, BUSY_D, DRAIN_I.
- IDLE: pick grant, latch fields into m_req_* regs, go BUSY_I/BUSY_D. None valid: stay.
- Grant rule: data wins unless i_req_valid && d_req_valid && streak == MAX_DATA_STREAK. Fetch is never granted in a cycle with flush high.
- Streak counter, width $clog2(MAX_DATA_STREAK+1): +1 on data grant with i_req_valid high; cleared on fetch grant or uncontested data grant; saturates.
- BUSY_x: m_req_valid=1, fields held. m_rsp_ready → pulse matching x_rsp_ready combinationally (rdata passthrough), go IDLE.
- flush in BUSY_I without m_rsp_ready → DRAIN_I. flush coincident with m_rsp_ready in BUSY_I → i_rsp_ready suppressed, go IDLE.
- DRAIN_I: m_req_valid held; i_rsp_ready never asserted; m_rsp_ready → IDLE, response discarded. Further flushes ignored.
- flush has no effect in BUSY_D or on the streak counter.
- i_rsp_ready/d_rsp_ready are 0 outside BUSY_I/BUSY_D respectively; rdata outputs are don't-care when ready=0.

## Timing
- Reset: state IDLE, streak 0, m_req_valid 0, m_req_* 0; i_rsp_ready, d_rsp_ready 0.
- Grant in IDLE cycle T; m_req_valid high from T+1; downstream latency ≥1, so earliest completion T+2; back in IDLE T+3.
- Response path adds zero cycles (combinational from m_rsp_ready/m_rsp_rdata).
- m_rsp_ready in IDLE is a protocol error; ignored.
- rst mid-transaction abandons it; the downstream port shares rst and is reset too.

## Structure
- core_pkg: mem_arb_state_e (IDLE, BUSY_I, BUSY_D, DRAIN_I), mem_grant_e (GRANT_I, GRANT_D), request struct {addr, wen, wdata, wmask}.
- Optional sub-module core_mem_arb_prio: combinational grant decision plus streak counter; FSM and latches stay in core_mem_arbiter.

## Test plan
- Fetch only: i_req addr 0x100, memory latency 1 → m_req_valid at T+1 addr 0x100, i_rsp_ready at T+2 with mem[0x100], IDLE at T+3.
- Simultaneous i/d continuously valid, MAX_DATA_STREAK=4 → grant order D,D,D,D,I,D,D,D,D,I.
- Store: d_req addr 0x40, wen=1, wdata 0xCAFEF00D, wmask 0xF → m_req_* match exactly; d_rsp_ready one cycle; i_rsp_ready stays 0.
- Flush in BUSY_I with latency 3 → DRAIN_I; m_req_valid held until m_rsp_ready; no i_rsp_ready; next grant proceeds normally.
- Flush coincident with m_rsp_ready in BUSY_I → no i_rsp_ready, IDLE next; flush in IDLE with only fetch pending → no grant that cycle.
- rst asserted in BUSY_D → next cycle all outputs 0, state IDLE, streak 0.
